// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for a simple single-bus datapath. Each instruction
// is fetched in T0..T2 (T1 stretches until memory reports read data valid).
// From T3 on, the datapath IR contents are decoded into a short per-class
// execute sequence.
//
// Ports
//   clk        : system clock; all state changes happen on its rising edge
//   clr_n      : asynchronous active-low reset
//   run        : start / continue fetching instructions
//   mem_ready  : memory read data valid (sampled only in T1)
//   ir[31:0]   : datapath IR contents
//                op = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15]
//   PCOut .. LOIn : 1-bit datapath strobes
//   r_in[15:0] : one-hot register load enable
//   r_out[15:0]: one-hot register bus drive enable
//   opcode[4:0]: ALU operation; nonzero only in the ALU step
//   t_state[2:0]: current step (0..6 in T0..T6, 7 in IDLE and HALT)
//   instr_done : single-cycle pulse in the last step of each instruction
//   halted     : high while the sequencer is stopped on an unknown opcode
//
// Valid/ready: mem_ready acts as the "valid" side of the memory read. The
// sequencer holds the T1 strobes (its standing request) on every cycle until
// it samples mem_ready=1 on a rising edge. It then moves to T2 on that same
// edge. No other input has a handshake.
//
// All outputs are a decode of the state register and of ir. ir is the
// datapath's own IR register and is stable while it is decoded, from T3 onward.
// run and mem_ready only steer the next state. So no combinational path
// runs from them to any output, and reset reaches the outputs through the
// state register alone.
// ---------------------------------------------------------------------------
module control_sequencer (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        PCOut,
  output logic        MARIn,
  output logic        PCinc_en,
  output logic        Z_en,
  output logic        Zlow_en,
  output logic        Zhigh_en,
  output logic        PCIn,
  output logic        MDRread,
  output logic        MDRIn,
  output logic        MDROut,
  output logic        IRIn,
  output logic        Y_en,
  output logic        HIIn,
  output logic        LOIn,
  output logic [15:0] r_in,
  output logic [15:0] r_out,
  output logic [4:0]  opcode,
  output logic [2:0]  t_state,
  output logic        instr_done,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  state_t state;

  // Instruction fields
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];

  // Immediate / unused low IR bits are not needed by the sequencer
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[14:0];

  // Opcode classes
  logic is_binary, is_muldiv, is_unary;
  always_comb begin
    is_binary = 1'b0;
    is_muldiv = 1'b0;
    is_unary  = 1'b0;
    case (op)
      5'b00101, 5'b00110, 5'b00111, 5'b01000,
      5'b01001, 5'b01011, 5'b01100, 5'b01101: is_binary = 1'b1;
      5'b10001, 5'b10010:                     is_muldiv = 1'b1;
      5'b10011, 5'b10100:                     is_unary  = 1'b1;
      default: ;
    endcase
  end

  // Register decoders; each output is driven by at most one of them per step
  logic [15:0] ra_oh, rb_oh, rc_oh;
  assign ra_oh = 16'd1 << ra;
  assign rb_oh = 16'd1 << rb;
  assign rc_oh = 16'd1 << rc;

  // Step after the instruction's last step: keep fetching only while run is high
  state_t after_done;
  assign after_done = run ? S_T0 : S_IDLE;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   if (mem_ready) state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3:   state <= (is_binary || is_muldiv || is_unary) ? S_T4 : S_HALT;
        // neg/not finish in T4; every other legal class continues to T5
        S_T4:   state <= is_unary ? after_done : S_T5;
        // mul/div need T6 to move the high half of the product/remainder
        S_T5:   state <= is_muldiv ? S_T6 : after_done;
        S_T6:   state <= after_done;
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Moore output decode
  // -------------------------------------------------------------------------
  always_comb begin
    PCOut      = 1'b0;
    MARIn      = 1'b0;
    PCinc_en   = 1'b0;
    Z_en       = 1'b0;
    Zlow_en    = 1'b0;
    Zhigh_en   = 1'b0;
    PCIn       = 1'b0;
    MDRread    = 1'b0;
    MDRIn      = 1'b0;
    MDROut     = 1'b0;
    IRIn       = 1'b0;
    Y_en       = 1'b0;
    HIIn       = 1'b0;
    LOIn       = 1'b0;
    r_in       = 16'd0;
    r_out      = 16'd0;
    opcode     = 5'd0;
    t_state    = 3'd7;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state)
      S_T0: begin
        t_state  = 3'd0;
        PCOut    = 1'b1;
        MARIn    = 1'b1;
        PCinc_en = 1'b1;
        Z_en     = 1'b1;
      end
      S_T1: begin
        t_state = 3'd1;
        Zlow_en = 1'b1;
        PCIn    = 1'b1;
        MDRread = 1'b1;
        MDRIn   = 1'b1;
      end
      S_T2: begin
        t_state = 3'd2;
        MDROut  = 1'b1;
        IRIn    = 1'b1;
      end
      S_T3: begin
        t_state = 3'd3;
        if (is_binary) begin
          r_out = rb_oh;
          Y_en  = 1'b1;
        end else if (is_muldiv) begin
          r_out = ra_oh;
          Y_en  = 1'b1;
        end else if (is_unary) begin
          r_out  = rb_oh;
          opcode = op;
          Z_en   = 1'b1;
        end
      end
      S_T4: begin
        t_state = 3'd4;
        if (is_unary) begin
          Zlow_en    = 1'b1;
          r_in       = ra_oh;
          instr_done = 1'b1;
        end else begin
          r_out  = is_muldiv ? rb_oh : rc_oh;
          opcode = op;
          Z_en   = 1'b1;
        end
      end
      S_T5: begin
        t_state = 3'd5;
        Zlow_en = 1'b1;
        if (is_muldiv) begin
          LOIn = 1'b1;
        end else begin
          r_in       = ra_oh;
          instr_done = 1'b1;
        end
      end
      S_T6: begin
        t_state    = 3'd6;
        Zhigh_en   = 1'b1;
        HIIn       = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
